rectangle128_keysched: RTL and testbench

RECTANGLE128_KEYSCHED -- requirements
Module: rectangle128_keysched

---
 rtl/rectangle128_pkg.sv | 30 +++
 rtl/rectangle128_keysched_if.sv | 21 ++
 rtl/rectangle128_ksg_round.sv | 25 ++
 rtl/rectangle128_keysched.sv | 112 +++++++++++
 tb/tb_rectangle128_keysched.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/rectangle128_pkg.sv
// Shared types and constants for the RECTANGLE-128 key schedule: S-box, round-constant step, FSM states.
package rectangle128_pkg;

   localparam int          NUM_SUBKEYS = 26;
   localparam logic [4:0]  RC_INIT     = 5'h01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CLR  = 2'd1,
      ST_GEN  = 2'd2,
      ST_DONE = 2'd3
   } ks_state_e;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h6;  4'h1: y = 4'h5;  4'h2: y = 4'hC;  4'h3: y = 4'hA;
         4'h4: y = 4'h1;  4'h5: y = 4'hE;  4'h6: y = 4'h7;  4'h7: y = 4'h9;
         4'h8: y = 4'hB;  4'h9: y = 4'h0;  4'hA: y = 4'h3;  4'hB: y = 4'hD;
         4'hC: y = 4'h8;  4'hD: y = 4'hF;  4'hE: y = 4'h4;  default: y = 4'h2;
      endcase
      return y;
   endfunction

   // 5-bit LFSR: shift left, feedback rc4 ^ rc2
   function automatic logic [4:0] rc_step(input logic [4:0] rc);
      return {rc[3:0], rc[4] ^ rc[2]};
   endfunction

endpackage

// File: rtl/rectangle128_keysched_if.sv
// Request/subkey-memory bundle between the key-schedule controller and its user.
interface rectangle128_keysched_if;
   logic          start;
   logic [127:0]  Key;
   logic          busy;
   logic          done;
   logic          MemFlush_n;
   logic          WE;
   logic [4:0]    WAddr;
   logic [63:0]   KeyIn;

   modport master (
      output start, Key,
      input  busy, done, MemFlush_n, WE, WAddr, KeyIn
   );

   modport slave (
      input  start, Key,
      output busy, done, MemFlush_n, WE, WAddr, KeyIn
   );
endinterface

// File: rtl/rectangle128_ksg_round.sv
// One combinational key-schedule round: S-box on columns 0..7, Feistel-like row mix, RC injection.
module rectangle128_ksg_round
   import rectangle128_pkg::*;
(
   input  logic [3:0][31:0] rows_i,
   input  logic [4:0]       rc_i,
   output logic [3:0][31:0] rows_o
);

   logic [3:0][31:0] sub;

   always_comb begin
      sub = rows_i;
      for (int j = 0; j < 8; j++) begin
         {sub[3][j], sub[2][j], sub[1][j], sub[0][j]} =
            sbox({rows_i[3][j], rows_i[2][j], rows_i[1][j], rows_i[0][j]});
      end
   end

   assign rows_o[0] = {sub[0][23:0], sub[0][31:24]} ^ sub[1] ^ {27'd0, rc_i};
   assign rows_o[1] = sub[2];
   assign rows_o[2] = sub[3];
   assign rows_o[3] = {sub[3][15:0], sub[3][31:16]} ^ sub[0];

endmodule

// File: rtl/rectangle128_keysched.sv
// RECTANGLE-128 subkey generator: expands a 128-bit key into 26 64-bit subkeys written to memory.
// Optional build macro RECTANGLE128_KEYSCHED_ZEROIZE_EN clears the key state after completion.
//
// state | meaning
// IDLE  | waiting for start; Key latched on accept
// CLR   | one-cycle active-low clear of the subkey memory
// GEN   | write subkey WAddr each cycle, advance key state
// DONE  | one-cycle done pulse, then back to IDLE
module rectangle128_keysched
   import rectangle128_pkg::*;
(
   input  logic Clk,
   input  logic flush,
   rectangle128_keysched_if.slave ks
);

   ks_state_e        state_q, state_d;
   logic [3:0][31:0] rows_q, rows_d, rows_nxt;
   logic [4:0]       rc_q, rc_d;
   logic [4:0]       waddr_q, waddr_d;
   logic             we_q, we_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             mflush_n_q, mflush_n_d;

   rectangle128_ksg_round u_round (
      .rows_i (rows_q),
      .rc_i   (rc_q),
      .rows_o (rows_nxt)
   );

   always_comb begin
      state_d    = state_q;
      rows_d     = rows_q;
      rc_d       = rc_q;
      waddr_d    = waddr_q;
      we_d       = we_q;
      busy_d     = busy_q;
      done_d     = done_q;
      mflush_n_d = mflush_n_q;
      case (state_q)
         ST_IDLE: begin
            if (ks.start) begin
               state_d    = ST_CLR;
               rows_d     = ks.Key;
               rc_d       = RC_INIT;
               waddr_d    = 5'd0;
               busy_d     = 1'b1;
               mflush_n_d = 1'b0;
            end
         end
         ST_CLR: begin
            state_d    = ST_GEN;
            mflush_n_d = 1'b1;
            we_d       = 1'b1;
            waddr_d    = 5'd0;
         end
         ST_GEN: begin
            // last index is written without advancing, so the state keeps K25
            if (waddr_q == 5'(NUM_SUBKEYS - 1)) begin
               state_d = ST_DONE;
               we_d    = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               waddr_d = waddr_q + 5'd1;
               rows_d  = rows_nxt;
               rc_d    = rc_step(rc_q);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            waddr_d = 5'd0;
`ifdef RECTANGLE128_KEYSCHED_ZEROIZE_EN
            rows_d  = '0;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (flush) begin
         state_q    <= ST_IDLE;
         rows_q     <= '0;
         rc_q       <= RC_INIT;
         waddr_q    <= 5'd0;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         mflush_n_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         rc_q       <= rc_d;
         waddr_q    <= waddr_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         mflush_n_q <= mflush_n_d;
      end
   end

   assign ks.busy       = busy_q;
   assign ks.done       = done_q;
   assign ks.MemFlush_n = mflush_n_q;
   assign ks.WE         = we_q;
   assign ks.WAddr      = waddr_q;
   assign ks.KeyIn      = {rows_q[3][15:0], rows_q[2][15:0], rows_q[1][15:0], rows_q[0][15:0]};

endmodule

// File: tb/tb_rectangle128_keysched.sv
// Directed bench for rectangle128_keysched: hand vectors for key 0, reference model for other keys.
module tb_rectangle128_keysched;

   logic Clk;
   logic flush;
   rectangle128_keysched_if ks_if ();

   rectangle128_keysched dut (
      .Clk   (Clk),
      .flush (flush),
      .ks    (ks_if.slave)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_ks [26];
   logic [63:0] obs_k1, obs_k2;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref_sbox(input logic [3:0] x);
      logic [63:0] tbl;
      tbl = 64'h2_4_F_8_D_3_0_B_9_7_E_1_A_C_5_6;
      return tbl[x*4 +: 4];
   endfunction

   task automatic build_model(input logic [127:0] key);
      logic [31:0] r0, r1, r2, r3, n0, n3;
      logic [3:0]  nib, s;
      logic [4:0]  rc;
      r0 = key[31:0];  r1 = key[63:32];  r2 = key[95:64];  r3 = key[127:96];
      rc = 5'h01;
      for (int i = 0; i < 26; i++) begin
         exp_ks[i] = {r3[15:0], r2[15:0], r1[15:0], r0[15:0]};
         for (int j = 0; j < 8; j++) begin
            nib = {r3[j], r2[j], r1[j], r0[j]};
            s = ref_sbox(nib);
            r0[j] = s[0]; r1[j] = s[1]; r2[j] = s[2]; r3[j] = s[3];
         end
         n0 = {r0[23:0], r0[31:24]} ^ r1;
         n3 = {r3[15:0], r3[31:16]} ^ r0;
         r1 = r2;
         r2 = r3;
         r0 = n0 ^ {27'd0, rc};
         r3 = n3;
         rc = {rc[3:0], rc[4] ^ rc[2]};
      end
   endtask

   // start asserted in cycle T; optional stray start at T+5
   task automatic run_key(input logic [127:0] key, input bit stray_start, input string nm);
      build_model(key);
      ks_if.Key   = key;
      ks_if.start = 1'b1;
      tick();
      ks_if.start = 1'b0;
      ks_if.Key   = ~key;
      chk({nm, ".clr_mflush_n"}, 64'(ks_if.MemFlush_n), 64'd0);
      chk({nm, ".clr_we"},       64'(ks_if.WE),         64'd0);
      chk({nm, ".clr_busy"},     64'(ks_if.busy),       64'd1);
      for (int i = 0; i < 26; i++) begin
         tick();
         if (i == 1) obs_k1 = ks_if.KeyIn;
         if (i == 2) obs_k2 = ks_if.KeyIn;
         chk($sformatf("%s.we[%0d]", nm, i),    64'(ks_if.WE),         64'd1);
         chk($sformatf("%s.waddr[%0d]", nm, i), 64'(ks_if.WAddr),      64'(i));
         chk($sformatf("%s.keyin[%0d]", nm, i), ks_if.KeyIn,           exp_ks[i]);
         chk($sformatf("%s.mfl[%0d]", nm, i),   64'(ks_if.MemFlush_n), 64'd1);
         chk($sformatf("%s.done[%0d]", nm, i),  64'(ks_if.done),       64'd0);
         chk($sformatf("%s.busy[%0d]", nm, i),  64'(ks_if.busy),       64'd1);
         ks_if.start = (stray_start && i == 3) ? 1'b1 : 1'b0;
      end
      tick();
      ks_if.start = 1'b0;
      chk({nm, ".done_pulse"}, 64'(ks_if.done), 64'd1);
      chk({nm, ".done_busy"},  64'(ks_if.busy), 64'd0);
      chk({nm, ".done_we"},    64'(ks_if.WE),   64'd0);
      tick();
      chk({nm, ".idle_done"}, 64'(ks_if.done), 64'd0);
      chk({nm, ".idle_busy"}, 64'(ks_if.busy), 64'd0);
      chk({nm, ".idle_we"},   64'(ks_if.WE),   64'd0);
`ifdef RECTANGLE128_KEYSCHED_ZEROIZE_EN
      chk({nm, ".idle_keyin"}, ks_if.KeyIn, 64'd0);
`else
      chk({nm, ".idle_keyin"}, ks_if.KeyIn, exp_ks[25]);
`endif
   endtask

   initial begin
      flush       = 1'b1;
      ks_if.start = 1'b0;
      ks_if.Key   = '0;
      tick();
      tick();
      flush = 1'b0;

      chk("rst.busy",   64'(ks_if.busy),       64'd0);
      chk("rst.done",   64'(ks_if.done),       64'd0);
      chk("rst.we",     64'(ks_if.WE),         64'd0);
      chk("rst.waddr",  64'(ks_if.WAddr),      64'd0);
      chk("rst.mfl_n",  64'(ks_if.MemFlush_n), 64'd1);
      chk("rst.keyin",  ks_if.KeyIn,           64'd0);

      run_key(128'd0, 1'b0, "k0");
      chk("k0.hand_k1", obs_k1, 64'h0000_0000_00FF_00FE);
      chk("k0.hand_k2", obs_k2, 64'h0000_00FF_0001_00FC);

      run_key(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, "kpat");
      run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1, "krnd_stray");
      run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0, "krnd");

      // abort while WAddr 12 is being written
      ks_if.Key   = 128'hFFFF_FFFF_0000_0000_AAAA_5555_1234_5678;
      ks_if.start = 1'b1;
      tick();
      ks_if.start = 1'b0;
      for (int i = 0; i < 13; i++) tick();
      chk("abort.at_waddr12", 64'(ks_if.WAddr), 64'd12);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("abort.we",    64'(ks_if.WE),         64'd0);
      chk("abort.waddr", 64'(ks_if.WAddr),      64'd0);
      chk("abort.busy",  64'(ks_if.busy),       64'd0);
      chk("abort.done",  64'(ks_if.done),       64'd0);
      chk("abort.mfl_n", 64'(ks_if.MemFlush_n), 64'd1);
      chk("abort.keyin", ks_if.KeyIn,           64'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk($sformatf("abort.quiet_we[%0d]", i),   64'(ks_if.WE),   64'd0);
         chk($sformatf("abort.quiet_done[%0d]", i), 64'(ks_if.done), 64'd0);
      end

      // flush and start together: flush wins
      flush       = 1'b1;
      ks_if.start = 1'b1;
      tick();
      flush       = 1'b0;
      ks_if.start = 1'b0;
      chk("flush_start.busy",  64'(ks_if.busy),       64'd0);
      chk("flush_start.mfl_n", 64'(ks_if.MemFlush_n), 64'd1);
      tick();
      chk("flush_start.we",    64'(ks_if.WE),         64'd0);

      run_key(128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 1'b0, "restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
